// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - OpCodeEnum package: ALU opcodes, sequencer states, opcode helper
package OpCodeEnum;

    // Opcode encodings 10..15 are deliberately left undefined and flagged as errors
    typedef enum logic [3:0] {
        Add = 4'd0,
        Sub = 4'd1,
        And = 4'd2,
        Or  = 4'd3,
        Xor = 4'd4,
        Mul = 4'd5,
        Div = 4'd6,
        Mod = 4'd7,
        Shl = 4'd8,
        Shr = 4'd9
    } OpCode;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LAST = 4'd9;

    function automatic logic op_defined(input logic [3:0] code);
        return code <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_sequencer_btn.sv
// rtl/alu_sequencer_btn.sv - btn_conditioner: sync, optional debounce (BTN_DEBOUNCE_EN), rising-edge pulse
module btn_conditioner #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    // All conditioning flops reset to 1 so that a button held across reset
    // release is seen as "already pressed" and never produces a pulse.
    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          stable_q;

    // Accept a new level only after it differs from the stable one for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = stable_q;
`else
    logic unused_deb;
    assign unused_deb = (DEB_CYCLES != 0);
    assign level      = sync2_q;
`endif

    // Previous conditioned level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b1;
        end else begin
            level_prev_q <= level;
        end
    end

    assign press = level & ~level_prev_q;

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - button-stepped operand/op loader and result latch for an external ALU (BTN_DEBOUNCE_EN)
module alu_sequencer
    import OpCodeEnum::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_next,
    input  logic [N-1:0] sw_data,
    input  OpCode        sw_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output OpCode        op,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         result_valid,
    output logic         err,
    output logic [2:0]   state
);

    logic         press;
    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q, result_q;
    OpCode        op_q;
    logic [3:0]   flags_q;
    logic         valid_q, err_q;

    logic         load_a_en, load_b_en, load_op_en, exec_en, clear_en;
    logic [N-1:0] result_d;
    logic [3:0]   flags_d;
    logic         err_d;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next),
        .press (press)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every step waits for a press except EXEC, which always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (press) state_d = LOAD_B;
            LOAD_B:  if (press) state_d = LOAD_OP;
            LOAD_OP: if (press) state_d = EXEC;
            EXEC:    state_d = SHOW;
            SHOW:    if (press) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // Output decode: register enables and the value to latch at the end of EXEC
    always_comb begin
        load_a_en  = (state_q == LOAD_A)  && press;
        load_b_en  = (state_q == LOAD_B)  && press;
        load_op_en = (state_q == LOAD_OP) && press;
        exec_en    = (state_q == EXEC);
        clear_en   = (state_q == SHOW)    && press;
        result_d   = alu_out;
        flags_d    = {alu_z, alu_n, alu_v, alu_c};
        err_d      = 1'b0;
        if (!op_defined(op_q)) begin
            result_d = '0;
            flags_d  = 4'b0000;
            err_d    = 1'b1;
        end else if ((op_q == Div || op_q == Mod) && b_q == '0) begin
            result_d = '1;
            flags_d  = 4'b0000;
            err_d    = 1'b1;
        end
    end

    // Operand and opcode capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= Add;
        end else begin
            if (load_a_en)  a_q  <= sw_data;
            if (load_b_en)  b_q  <= sw_data;
            if (load_op_en) op_q <= sw_op;
        end
    end

    // Result latch: filled leaving EXEC, valid/err dropped by the press that leaves SHOW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (exec_en) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            valid_q  <= 1'b1;
        end else if (clear_en) begin
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign op           = op_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = valid_q;
    assign err          = err_q;
    assign state        = state_q;

endmodule
